// File: rtl/rv32_ex_stage.sv
// pito RV32 execute stage: operand select, ALU, branch/jump resolution, registered 2-deep output.
// Optional perf counters are built only when RV32_EX_PERF_EN is defined.
`timescale 1ns/1ps

package rv32_ex_pkg;

    // Compare ops return 0/1 in bit 0; SBT/SBTU are "A >= B" (signed/unsigned).
    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_EQ,
        ALU_NEQ,
        ALU_SBT,
        ALU_SBTU,
        ALU_PASSB
    } rv32_alu_op_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic        rd_we;
        logic [31:0] result;
        logic        redirect;
        logic [31:0] target;
    } ex_pay_t;

endpackage

module rv32_alu
    import rv32_ex_pkg::*;
(
    input  logic [31:0]  a,
    input  logic [31:0]  b,
    input  rv32_alu_op_t op,
    output logic [31:0]  res
);

    logic [4:0] shamt;

    assign shamt = b[4:0];

    // Single-cycle combinational ALU.
    always_comb begin
        res = '0;
        unique case (op)
            ALU_ADD:   res = a + b;
            ALU_SUB:   res = a - b;
            ALU_SLL:   res = a << shamt;
            ALU_SLT:   res = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU:  res = {31'd0, a < b};
            ALU_XOR:   res = a ^ b;
            ALU_SRL:   res = a >> shamt;
            ALU_SRA:   res = $unsigned($signed(a) >>> shamt);
            ALU_OR:    res = a | b;
            ALU_AND:   res = a & b;
            ALU_EQ:    res = {31'd0, a == b};
            ALU_NEQ:   res = {31'd0, a != b};
            ALU_SBT:   res = {31'd0, $signed(a) >= $signed(b)};
            ALU_SBTU:  res = {31'd0, a >= b};
            ALU_PASSB: res = b;
            default:   res = '0;
        endcase
    end

endmodule

module rv32_ex_stage
    import rv32_ex_pkg::*;
#(
    parameter int HART_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [HART_W-1:0] in_hart_id,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_rs1_data,
    input  logic [31:0]       in_rs2_data,
    input  logic [31:0]       in_imm,
    input  logic              in_a_sel,
    input  logic              in_b_sel,
    input  rv32_alu_op_t      in_alu_op,
    input  logic [4:0]        in_rd,
    input  logic              in_rd_we,
    input  logic              in_is_branch,
    input  logic              in_is_jump,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [HART_W-1:0] out_hart_id,
    output logic [4:0]        out_rd,
    output logic              out_rd_we,
    output logic [31:0]       out_result,
    output logic              out_redirect,
    output logic [31:0]       out_target,
    output logic [31:0]       perf_ops,
    output logic [31:0]       perf_redirects
);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_TWO
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [31:0]       op_a;
    logic [31:0]       op_b;
    logic [31:0]       alu_res;
    logic [31:0]       br_target;
    logic [31:0]       link;

    ex_pay_t           pay_in;
    ex_pay_t           or_pay;
    ex_pay_t           sk_pay;
    logic [HART_W-1:0] or_hart;
    logic [HART_W-1:0] sk_hart;

    logic              in_xfer;
    logic              out_xfer;
    logic              or_load_in;
    logic              or_load_sk;
    logic              sk_load;

    assign op_a = in_a_sel ? in_pc  : in_rs1_data;
    assign op_b = in_b_sel ? in_imm : in_rs2_data;

    rv32_alu u_alu (
        .a   (op_a),
        .b   (op_b),
        .op  (in_alu_op),
        .res (alu_res)
    );

    // Branch target has its own adder so the ALU is free for the compare.
    assign br_target = in_pc + in_imm;
    assign link      = in_pc + 32'd4;

    // Build the payload for the op currently offered by decode.
    always_comb begin
        pay_in          = '0;
        pay_in.rd       = in_rd;
        pay_in.rd_we    = in_rd_we && (in_rd != 5'd0);
        pay_in.result   = alu_res;
        pay_in.redirect = 1'b0;
        pay_in.target   = '0;
        if (in_is_branch) begin
            pay_in.redirect = alu_res[0];
            pay_in.target   = br_target;
            pay_in.rd_we    = 1'b0;
            pay_in.result   = '0;
        end else if (in_is_jump) begin
            pay_in.redirect = 1'b1;
            pay_in.target   = {alu_res[31:1], 1'b0};
            pay_in.result   = link;
        end
    end

    assign out_valid = (state != S_EMPTY);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    // Occupancy FSM: decide next state and which slot loads what.
    always_comb begin
        state_nxt  = state;
        or_load_in = 1'b0;
        or_load_sk = 1'b0;
        sk_load    = 1'b0;
        unique case (state)
            S_EMPTY: begin
                if (in_xfer) begin
                    or_load_in = 1'b1;
                    state_nxt  = S_ONE;
                end
            end
            S_ONE: begin
                if (in_xfer && out_xfer) begin
                    or_load_in = 1'b1;
                end else if (in_xfer) begin
                    sk_load   = 1'b1;
                    state_nxt = S_TWO;
                end else if (out_xfer) begin
                    state_nxt = S_EMPTY;
                end
            end
            S_TWO: begin
                if (out_xfer) begin
                    or_load_sk = 1'b1;
                    state_nxt  = S_ONE;
                end
            end
            default: state_nxt = S_EMPTY;
        endcase
    end

    // State register; in_ready is registered so it has no path from out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != S_TWO);
        end
    end

    // Output register: fresh op from decode or the op parked in the skid slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            or_pay  <= '0;
            or_hart <= '0;
        end else if (or_load_in) begin
            or_pay  <= pay_in;
            or_hart <= in_hart_id;
        end else if (or_load_sk) begin
            or_pay  <= sk_pay;
            or_hart <= sk_hart;
        end
    end

    // Skid slot catches the op accepted while the output is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            sk_pay  <= '0;
            sk_hart <= '0;
        end else if (sk_load) begin
            sk_pay  <= pay_in;
            sk_hart <= in_hart_id;
        end
    end

    assign out_hart_id  = or_hart;
    assign out_rd       = or_pay.rd;
    assign out_rd_we    = or_pay.rd_we;
    assign out_result   = or_pay.result;
    assign out_redirect = or_pay.redirect;
    assign out_target   = or_pay.target;

`ifdef RV32_EX_PERF_EN
    logic [31:0] ops_q;
    logic [31:0] redir_q;

    // Count retired ops and redirects on output transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ops_q   <= '0;
            redir_q <= '0;
        end else if (out_xfer) begin
            ops_q <= ops_q + 32'd1;
            if (or_pay.redirect) begin
                redir_q <= redir_q + 32'd1;
            end
        end
    end

    assign perf_ops       = ops_q;
    assign perf_redirects = redir_q;
`else
    assign perf_ops       = '0;
    assign perf_redirects = '0;
`endif

endmodule

// File: doc/rv32_ex_stage.md
# rv32_ex_stage

Registered execute stage of the pito RV32 barrel core: sits between decode/register-read and writeback and wraps one `rv32_alu` instance. Selects ALU operands, resolves branches and jumps, and registers result and control-flow decision into a valid/ready output slot. A skid buffer keeps `in_ready` a pure register output.

## Interface
- `HART_W`, 3: hart-id tag width (8 harts).
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  decode offers an op.
- `in_ready`  out  1  stage can accept; registered, equals "skid buffer empty".
- `in_hart_id`  in  HART_W  issuing hart.
- `in_pc`  in  32  PC of the op.
- `in_rs1_data`, `in_rs2_data`  in  32 each  register-file read data.
- `in_imm`  in  32  sign-extended immediate.
- `in_a_sel`  in  1  0 = rs1, 1 = pc as ALU operand A.
- `in_b_sel`  in  1  0 = rs2, 1 = imm as ALU operand B.
- `in_alu_op`  in  rv32_alu_op_t  ALU opcode (`ALU_*`).
- `in_rd`  in  5  destination register.
- `in_rd_we`  in  1  op writes rd.
- `in_is_branch`, `in_is_jump`  in  1 each  conditional branch / JAL-JALR (mutually exclusive).
- `out_valid`  out  1  result slot full.
- `out_ready`  in  1  writeback accepts.
- `out_hart_id`, `out_rd`, `out_rd_we`  out  HART_W/5/1  forwarded tags.
- `out_result`  out  32  value for rd.
- `out_redirect`  out  1  PC of `out_hart_id` must change.
- `out_target`  out  32  new PC when `out_redirect`.
- `perf_ops`, `perf_redirects`  out  32 each  counters (see Configuration).

## Operation
- A = `in_a_sel` ? pc : rs1; B = `in_b_sel` ? imm : rs2; both to `rv32_alu`.
- Plain op: result = ALU res; redirect = 0; target = 0.
- Branch (ALU op one of EQ/NEQ/SLT/SLTU/SBT/SBTU, A=rs1, B=rs2): redirect = ALU res[0]; target = pc + imm (dedicated 32-bit adder, wraps mod 2^32); rd_we forced 0; result = 0.
- Jump: ALU computes A+B; target = {res[31:1],1'b0}; redirect = 1; result = pc + 4 (wraps, 0xFFFFFFFC → 0x00000000).
- `in_rd == 0`: rd_we forced 0 on output.
- Storage: output register (OR) + one skid entry (SK). Transfer in = `in_valid && in_ready`; transfer out = `out_valid && out_ready`.
- States: EMPTY (OR empty), ONE (OR full, SK empty), TWO (both full).
  - EMPTY: in → ONE (op into OR).
  - ONE: in & out → ONE (new op into OR); in & !out → TWO (op into SK); out only → EMPTY.
  - TWO: `in_ready`=0; out → ONE (SK moves to OR); else hold.
- Order preserved; no op dropped or duplicated.

## Timing
- Latency: op accepted at edge N appears on `out_*` after edge N (cycle N+1) when the stage was EMPTY or ONE-with-out-transfer.
- Throughput: 1 op/cycle while `out_ready`=1.
- `in_ready` depends only on state (no comb. path from `out_ready`); deasserts the cycle after entering TWO.
- `out_*` stable while `out_valid && !out_ready`.
- Reset: state EMPTY; `in_ready`=1, `out_valid`=0; `out_result`, `out_target`, `out_hart_id`, `out_rd`=0; `out_rd_we`, `out_redirect`=0; counters 0. Reset mid-operation discards OR and SK contents, no output transfer that cycle.
- Payload registers outside reset value only update on accepted transfers.

## Configuration
- `RV32_EX_PERF_EN` defined: `perf_ops` increments on every output transfer, `perf_redirects` on output transfers with `out_redirect`=1; both wrap 0xFFFFFFFF → 0; cleared by `rst`.
- Undefined: counters not built, both ports tied to 0.

## Test plan
- ADD rs1=0x7FFFFFFF, rs2=1, `out_ready`=1 → next cycle `out_result`=0x80000000, `out_redirect`=0; back-to-back 8 ops, one per cycle, hart ids 0..7 in order.
- BEQ pc=0x100, imm=0xFFFFFFF0, rs1=rs2=5 → `out_redirect`=1, `out_target`=0xF0, `out_rd_we`=0; rs2=6 → `out_redirect`=0.
- JALR rs1=0x2003, imm=4, pc=0xFFFFFFFC, rd=1 → `out_target`=0x2006, `out_result`=0x00000000, `out_rd_we`=1; same with rd=0 → `out_rd_we`=0.
- Hold `out_ready`=0, offer 3 ops → 2 accepted, `in_ready`=0 from third cycle; release → ops emerge in order, `out_*` stable during stall.
- Assert `rst` while in TWO → next cycle `out_valid`=0, `in_ready`=1, all outputs 0.
- With `RV32_EX_PERF_EN`: 10 ops incl. 3 taken branches, 1 jump → `perf_ops`=10, `perf_redirects`=4; without macro both read 0.
